// File: rtl/papu_clk_pkg.sv
// papu_clk_pkg: shared types and rate constants for the PAPU clock-enable block.
// Rates are derived from the 49.259259 MHz audio PLL output.
package papu_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam int ACC_W_DEF   = 26;
  localparam int CPU_INC_DEF = 1789773;
  localparam int CPU_MOD_DEF = 49259259;
  localparam int SMP_INC_DEF = 44100;
  localparam int SMP_MOD_DEF = 49259259;

  function automatic int hold_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/papu_clk_enable_if.sv
// papu_clk_enable_if: lock input and reset/strobe outputs of the clock-enable block.
// master is the generator side, slave is the PAPU consumer side.
interface papu_clk_enable_if;

  logic pll_locked;
  logic sys_rst;
  logic running;
  logic cpu_ce;
  logic apu_ce;
  logic smp_ce;

  modport master (
    input  pll_locked,
    output sys_rst,
    output running,
    output cpu_ce,
    output apu_ce,
    output smp_ce
  );

  modport slave (
    output pll_locked,
    input  sys_rst,
    input  running,
    input  cpu_ce,
    input  apu_ce,
    input  smp_ce
  );

endinterface

// File: rtl/papu_nco.sv
// papu_nco: fractional phase accumulator producing a one-cycle strobe.
// Averages exactly INC strobes per MOD enabled cycles.
module papu_nco #(
  parameter int ACC_W = 26,
  parameter int INC   = 1789773,
  parameter int MOD   = 49259259
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic ce
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;
  logic [ACC_W:0]   over;
  logic             wrap;

  // one spare bit so acc+INC never wraps before the MOD compare
  assign sum  = {1'b0, acc} + (ACC_W+1)'(INC);
  assign wrap = sum >= (ACC_W+1)'(MOD);
  assign over = sum - (ACC_W+1)'(MOD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      ce  <= 1'b0;
    end else if (!en) begin
      acc <= '0;
      ce  <= 1'b0;
    end else if (wrap) begin
      acc <= over[ACC_W-1:0];
      ce  <= 1'b1;
    end else begin
      acc <= sum[ACC_W-1:0];
      ce  <= 1'b0;
    end
  end

endmodule

// File: rtl/papu_clk_enable.sv
// papu_clk_enable: PLL lock sync, reset sequencing and PAPU rate strobes.
// CPU, APU (CPU/2) and sample enables are qualified by the RUN state.
module papu_clk_enable
  import papu_clk_pkg::*;
#(
  parameter int LOCK_HOLD = 1024,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int CPU_INC   = CPU_INC_DEF,
  parameter int CPU_MOD   = CPU_MOD_DEF,
  parameter int SMP_INC   = SMP_INC_DEF,
  parameter int SMP_MOD   = SMP_MOD_DEF
) (
  input  logic               clk,
  input  logic               rst,
  papu_clk_enable_if.master  bus
);

  localparam int CW = hold_w(LOCK_HOLD);

  logic [1:0]    sync;
  logic          lock_s;
  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic          sys_rst_q;
  logic          running_q;
  logic          phase;
  logic          nco_en;
  logic          cpu_ce;
  logic          smp_ce;

  assign lock_s = sync[1];

  always_comb begin
    state_n = state;
    unique case (state)
      WAIT_LOCK: begin
        if (lock_s) state_n = HOLD;
      end
      HOLD: begin
        if (!lock_s)
          state_n = WAIT_LOCK;
        else if (cnt == CW'(LOCK_HOLD - 1))
          state_n = RUN;
      end
      RUN: begin
        if (!lock_s) state_n = WAIT_LOCK;
      end
      default: state_n = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync      <= 2'b00;
      state     <= WAIT_LOCK;
      cnt       <= '0;
      sys_rst_q <= 1'b1;
      running_q <= 1'b0;
    end else begin
      sync      <= {sync[0], bus.pll_locked};
      state     <= state_n;
      cnt       <= (state == HOLD) ? cnt + CW'(1) : '0;
      sys_rst_q <= (state_n != RUN);
      running_q <= (state_n == RUN);
    end
  end

  // drop the NCOs on the very edge that leaves RUN so no late strobe escapes
  assign nco_en = running_q & (state_n == RUN);

  papu_nco #(
    .ACC_W (ACC_W),
    .INC   (CPU_INC),
    .MOD   (CPU_MOD)
  ) u_cpu_nco (
    .clk (clk),
    .rst (rst),
    .en  (nco_en),
    .ce  (cpu_ce)
  );

  papu_nco #(
    .ACC_W (ACC_W),
    .INC   (SMP_INC),
    .MOD   (SMP_MOD)
  ) u_smp_nco (
    .clk (clk),
    .rst (rst),
    .en  (nco_en),
    .ce  (smp_ce)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      phase <= 1'b0;
    else if (!nco_en)
      phase <= 1'b0;
    else if (cpu_ce)
      phase <= ~phase;
  end

  assign bus.sys_rst = sys_rst_q;
  assign bus.running = running_q;
  assign bus.cpu_ce  = cpu_ce;
  assign bus.apu_ce  = cpu_ce & phase;
  assign bus.smp_ce  = smp_ce;

endmodule

// File: tb/tb_papu_clk_enable.sv
// tb_papu_clk_enable: scoreboard bench for lock sequencing and rate strobes.
// Expected edges are derived from lock timing and ceil(k*MOD/INC).
module tb_papu_clk_enable;

  localparam int LH = 16;
  localparam int CI = 2;
  localparam int CM = 7;
  localparam int SI = 1790;
  localparam int SM = 49259;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  int   q_rel[$];
  int   q_fall[$];
  int   q_cpu[$];
  int   q_smp[$];
  bit   q_apu[$];

  int   n_cpu, n_apu, n_smp;
  int   exp_cpu, exp_apu, exp_smp;
  int   last_cpu = -1;
  int   last_smp = -1;
  logic prev_sr = 1'b1;

  papu_clk_enable_if bus ();

  papu_clk_enable #(
    .LOCK_HOLD (LH),
    .ACC_W     (26),
    .CPU_INC   (CI),
    .CPU_MOD   (CM),
    .SMP_INC   (SI),
    .SMP_MOD   (SM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at edge %0d",
               tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_sr && !bus.sys_rst) begin
        if (q_rel.size() == 0) check("rel_extra", 1, 0);
        else check("rel_edge", cyc, q_rel.pop_front());
        check("run_on_rel", bus.running, 1);
      end
      if (!prev_sr && bus.sys_rst) begin
        if (q_fall.size() == 0) check("fall_extra", 1, 0);
        else check("fall_edge", cyc, q_fall.pop_front());
        check("run_on_fall", bus.running, 0);
      end
      if (bus.cpu_ce || bus.apu_ce || bus.smp_ce)
        check("ce_gate", bus.sys_rst, 0);
      if (bus.apu_ce)
        check("apu_with_cpu", bus.cpu_ce, 1);
      if (bus.cpu_ce) begin
        n_cpu++;
        if (bus.apu_ce) n_apu++;
        if (q_cpu.size() == 0) check("cpu_extra", 1, 0);
        else begin
          check("cpu_edge", cyc, q_cpu.pop_front());
          check("apu_phase", bus.apu_ce, q_apu.pop_front());
        end
        if (last_cpu >= 0)
          check("cpu_gap", (cyc - last_cpu >= CM / CI) &&
                           (cyc - last_cpu <= (CM + CI - 1) / CI), 1);
        last_cpu = cyc;
      end
      if (bus.smp_ce) begin
        n_smp++;
        if (q_smp.size() == 0) check("smp_extra", 1, 0);
        else check("smp_edge", cyc, q_smp.pop_front());
        if (last_smp >= 0)
          check("smp_gap", (cyc - last_smp >= SM / SI) &&
                           (cyc - last_smp <= (SM + SI - 1) / SI), 1);
        last_smp = cyc;
      end
    end
    prev_sr = bus.sys_rst;
  end

  task automatic push_exp(input int e, input int w);
    int m;
    q_rel.push_back(e);
    q_fall.push_back(e + w + 1);
    n_cpu = 0;
    n_apu = 0;
    n_smp = 0;
    last_cpu = -1;
    last_smp = -1;
    for (int k = 1; k <= w; k++) begin
      m = (k * CM + CI - 1) / CI;
      if (m > w) break;
      q_cpu.push_back(e + m);
      q_apu.push_back((k % 2) == 0);
    end
    for (int k = 1; k <= w; k++) begin
      m = (k * SM + SI - 1) / SI;
      if (m > w) break;
      q_smp.push_back(e + m);
    end
    exp_cpu = (w * CI) / CM;
    exp_apu = exp_cpu / 2;
    exp_smp = (w * SI) / SM;
  endtask

  task automatic lock_rise(input int w, output int e);
    bus.pll_locked = 1'b1;
    e = cyc + LH + 3;
    push_exp(e, w);
  endtask

  task automatic lock_drop(input int e, input int w);
    while (cyc < e + w - 2) @(negedge clk);
    bus.pll_locked = 1'b0;
    while (cyc < e + w + 4) @(negedge clk);
    check("lost_sys_rst", bus.sys_rst, 1);
    check("lost_running", bus.running, 0);
    check("rel_pending", q_rel.size(), 0);
    check("fall_pending", q_fall.size(), 0);
    check("cpu_pending", q_cpu.size(), 0);
    check("smp_pending", q_smp.size(), 0);
    check("cpu_count", n_cpu, exp_cpu);
    check("apu_count", n_apu, exp_apu);
    check("smp_count", n_smp, exp_smp);
  endtask

  initial begin
    int e;
    bus.pll_locked = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sys_rst", bus.sys_rst, 1);
    check("rst_running", bus.running, 0);
    check("rst_cpu_ce", bus.cpu_ce, 0);
    check("rst_apu_ce", bus.apu_ce, 0);
    check("rst_smp_ce", bus.smp_ce, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_sys_rst", bus.sys_rst, 1);

    lock_rise(700, e);
    lock_drop(e, 700);

    bus.pll_locked = 1'b1;
    repeat (10) @(negedge clk);
    bus.pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    lock_rise(SM, e);
    lock_drop(e, SM);

    repeat (4) @(negedge clk);
    lock_rise(120, e);
    lock_drop(e, 120);

    lock_rise(500, e);
    while (cyc < e + 50) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_sys_rst", bus.sys_rst, 1);
    check("arst_running", bus.running, 0);
    check("arst_cpu_ce", bus.cpu_ce, 0);
    check("arst_apu_ce", bus.apu_ce, 0);
    check("arst_smp_ce", bus.smp_ce, 0);
    q_rel.delete();
    q_fall.delete();
    q_cpu.delete();
    q_apu.delete();
    q_smp.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    lock_rise(60, e);
    lock_drop(e, 60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not complete by time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
